// File: rtl/generador_22_numeros_6bit_if.sv
// Stream bundle between the 22-member sequence generator and its consumer.
// The generator drives the word stream (master); the consumer drives the
// start request and the ready flag (slave).
// Optional macro GEN22_CUENTA_EN adds the 5-bit accepted-word counter Cuenta.
interface generador_22_numeros_6bit_if;
    logic       Inicio;
    logic       Listo;
    logic [5:0] Salida;
    logic       Valido;
    logic       Ocupado;
    logic       Hecho;
`ifdef GEN22_CUENTA_EN
    logic [4:0] Cuenta;

    modport master (
        input  Inicio, Listo,
        output Salida, Valido, Ocupado, Hecho, Cuenta
    );

    modport slave (
        output Inicio, Listo,
        input  Salida, Valido, Ocupado, Hecho, Cuenta
    );
`else
    modport master (
        input  Inicio, Listo,
        output Salida, Valido, Ocupado, Hecho
    );

    modport slave (
        output Inicio, Listo,
        input  Salida, Valido, Ocupado, Hecho
    );
`endif
endinterface

// File: rtl/generador_22_numeros_6bit.sv
// Sequence generator for the 6-bit, 22-member number set feeding the
// comparator path. A start request scans candidates 0..63 one per cycle and
// streams every member in ascending order over a valid/ready handshake,
// finishing with a one-cycle Hecho pulse. REPETIR=1 restarts the scan after
// every completion until reset.
// Optional macro GEN22_CUENTA_EN adds the Cuenta port counting accepted words
// in the current pass.
module generador_22_numeros_6bit #(
    parameter bit REPETIR = 1'b0
) (
    input  logic                              i_Reloj,
    input  logic                              i_Reset,
    generador_22_numeros_6bit_if.master       io_bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRENAR = 2'd2
    } estado_t;

    estado_t    r_estado;
    estado_t    w_estadoSig;
    logic [5:0] r_cand;
    logic [5:0] w_candSig;
    logic [5:0] r_salida;
    logic [5:0] w_salidaSig;
    logic       r_valido;
    logic       w_validoSig;
    logic       r_hecho;
    logic       w_hechoSig;
    logic       w_esMiembro;
    logic       w_avanza;
    logic       w_arranque;

    // Membership decode of the current candidate against the fixed 22-value set.
    always_comb begin
        w_esMiembro = 1'b0;
        case (r_cand)
            6'd1,  6'd2,  6'd3,  6'd5,  6'd10, 6'd12, 6'd13, 6'd15,
            6'd20, 6'd21, 6'd22, 6'd23, 6'd25, 6'd30, 6'd31, 6'd33,
            6'd35, 6'd36, 6'd50, 6'd51, 6'd52, 6'd53: w_esMiembro = 1'b1;
            default: w_esMiembro = 1'b0;
        endcase
    end

    // The scanner may only move when no word is stuck waiting for the
    // consumer; a start in IDLE is ignored during the Hecho cycle so a
    // request coinciding with completion never launches a new pass.
    assign w_avanza   = !r_valido || io_bus.Listo;
    assign w_arranque = (r_estado == IDLE) && io_bus.Inicio && !r_hecho;

    // Next-state and next-output logic for the scan/drain sequencer.
    always_comb begin
        w_estadoSig = r_estado;
        w_candSig   = r_cand;
        w_salidaSig = r_salida;
        w_validoSig = r_valido;
        w_hechoSig  = 1'b0;
        case (r_estado)
            IDLE: begin
                if (w_arranque) begin
                    w_estadoSig = RUN;
                    w_candSig   = 6'd0;
                end
            end
            RUN: begin
                if (w_avanza) begin
                    if (w_esMiembro) begin
                        w_salidaSig = r_cand;
                        w_validoSig = 1'b1;
                    end else begin
                        w_validoSig = 1'b0;
                    end
                    w_candSig = r_cand + 6'd1;
                    if (r_cand == 6'd63) begin
                        w_estadoSig = DRENAR;
                    end
                end
            end
            DRENAR: begin
                if (!(r_valido && !io_bus.Listo)) begin
                    w_validoSig = 1'b0;
                    w_hechoSig  = 1'b1;
                    w_candSig   = 6'd0;
                    if (REPETIR) begin
                        w_estadoSig = RUN;
                    end else begin
                        w_estadoSig = IDLE;
                    end
                end
            end
            default: begin
                w_estadoSig = IDLE;
                w_validoSig = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any pass and drops pending words.
    always_ff @(posedge i_Reloj or posedge i_Reset) begin
        if (i_Reset) begin
            r_estado <= IDLE;
            r_cand   <= 6'd0;
            r_salida <= 6'd0;
            r_valido <= 1'b0;
            r_hecho  <= 1'b0;
        end else begin
            r_estado <= w_estadoSig;
            r_cand   <= w_candSig;
            r_salida <= w_salidaSig;
            r_valido <= w_validoSig;
            r_hecho  <= w_hechoSig;
        end
    end

    assign io_bus.Salida  = r_salida;
    assign io_bus.Valido  = r_valido;
    assign io_bus.Hecho   = r_hecho;
    assign io_bus.Ocupado = (r_estado != IDLE);

`ifdef GEN22_CUENTA_EN
    logic [4:0] r_cuenta;
    logic [4:0] w_cuentaSig;
    logic       w_transfer;
    logic       w_limpiar;

    // Under REPETIR the restart edge coincides with Hecho rising, so the
    // counter is cleared one edge later (RUN while Hecho is high) to keep
    // the final count of 22 visible during the Hecho cycle.
    assign w_transfer = r_valido && io_bus.Listo;
    assign w_limpiar  = w_arranque || ((r_estado == RUN) && r_hecho);

    // Next value of the accepted-word counter.
    always_comb begin
        w_cuentaSig = r_cuenta;
        if (w_limpiar) begin
            w_cuentaSig = 5'd0;
        end else if (w_transfer) begin
            w_cuentaSig = r_cuenta + 5'd1;
        end
    end

    // Accepted-word counter register.
    always_ff @(posedge i_Reloj or posedge i_Reset) begin
        if (i_Reset) begin
            r_cuenta <= 5'd0;
        end else begin
            r_cuenta <= w_cuentaSig;
        end
    end

    assign io_bus.Cuenta = r_cuenta;
`endif

endmodule
